// File: rtl/complex_matrix_addsub_stream.sv
// complex_matrix_addsub_stream
// Loads ROWS x COLS complex operand pairs over a valid/ready input stream,
// computes element-wise A+B or A-B one element per cycle, then streams the
// results out over a valid/ready output port.
// Optional macro CMPLX_ADDSUB_SAT_EN: clamp each result part to the HW-bit
// signed range before sign-extending it back to RW bits.
module complex_matrix_addsub_stream #(
   parameter int ROWS = 2,
   parameter int COLS = 2,
   parameter int DW   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          op,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] b_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW+1:0] out_data,
   output logic          busy,
   output logic          done
);

   localparam int N  = ROWS * COLS;
   localparam int HW = DW / 2;
   localparam int RW = HW + 1;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

   state_t          state_reg, state_next;
   logic [IW-1:0]   index_reg, index_next;
   logic            op_reg, op_next;
   logic            done_reg, done_next;

   // Operand and result buffers; contents survive reset on purpose.
   logic [DW-1:0]   a_mem   [N];
   logic [DW-1:0]   b_mem   [N];
   logic [2*RW-1:0] res_mem [N];

   logic [DW-1:0]   a_rd_reg, b_rd_reg;
   logic [2*RW-1:0] out_data_reg;
   logic [2*RW-1:0] res_value;

   // Control strobes produced by the FSM
   logic            in_fire;
   logic            opnd_rd_en;
   logic [IW-1:0]   opnd_rd_addr;
   logic            res_wr_en;
   logic            out_ld_en;
   logic [IW-1:0]   out_ld_addr;
   logic            out_clr;

   // State register and transaction bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         index_reg <= '0;
         op_reg    <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
         op_reg    <= op_next;
         done_reg  <= done_next;
      end
   end

   // Next-state logic, handshake outputs and buffer strobes
   always_comb begin
      state_next   = state_reg;
      index_next   = index_reg;
      op_next      = op_reg;
      done_next    = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = (state_reg != IDLE);
      in_fire      = 1'b0;
      opnd_rd_en   = 1'b0;
      opnd_rd_addr = '0;
      res_wr_en    = 1'b0;
      out_ld_en    = 1'b0;
      out_ld_addr  = '0;
      out_clr      = 1'b0;
      case (state_reg)
         IDLE: begin
            // The done cycle still counts as the tail of the previous job.
            if (start && !done_reg) begin
               op_next    = op;
               index_next = '0;
               state_next = LOAD;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               in_fire = 1'b1;
               if (index_reg == LAST) begin
                  index_next   = '0;
                  state_next   = COMPUTE;
                  // Prefetch element 0 so COMPUTE starts with operands ready.
                  opnd_rd_en   = 1'b1;
                  opnd_rd_addr = '0;
               end else begin
                  index_next = index_reg + 1'b1;
               end
            end
         end
         COMPUTE: begin
            res_wr_en = 1'b1;
            if (index_reg == LAST) begin
               index_next  = '0;
               state_next  = OUTPUT;
               // Preload result 0 so out_data is valid in the first OUTPUT cycle.
               out_ld_en   = 1'b1;
               out_ld_addr = '0;
            end else begin
               index_next   = index_reg + 1'b1;
               opnd_rd_en   = 1'b1;
               opnd_rd_addr = index_reg + 1'b1;
            end
         end
         OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (index_reg == LAST) begin
                  index_next = '0;
                  state_next = IDLE;
                  done_next  = 1'b1;
                  out_clr    = 1'b1;
               end else begin
                  index_next  = index_reg + 1'b1;
                  out_ld_en   = 1'b1;
                  out_ld_addr = index_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand buffer write during LOAD
   always_ff @(posedge clk) begin
      if (in_fire) begin
         a_mem[index_reg] <= a_in;
         b_mem[index_reg] <= b_in;
      end
   end

   // Registered operand read; bypass covers the single-element case
   always_ff @(posedge clk) begin
      if (rst) begin
         a_rd_reg <= '0;
         b_rd_reg <= '0;
      end else if (opnd_rd_en) begin
         if (in_fire && (opnd_rd_addr == index_reg)) begin
            a_rd_reg <= a_in;
            b_rd_reg <= b_in;
         end else begin
            a_rd_reg <= a_mem[opnd_rd_addr];
            b_rd_reg <= b_mem[opnd_rd_addr];
         end
      end
   end

`ifdef CMPLX_ADDSUB_SAT_EN
   // Clamp an RW-bit exact result into the HW-bit signed range.
   function automatic logic [RW-1:0] clamp_part(input logic [RW-1:0] v);
      if (v[RW-1] != v[RW-2])
         return v[RW-1] ? {2'b11, {(HW-1){1'b0}}} : {2'b00, {(HW-1){1'b1}}};
      return v;
   endfunction
`endif

   // Lane 0 is the imaginary part, lane 1 the real part.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_part
         logic [RW-1:0] a_x, b_x, sum;
         assign a_x = {a_rd_reg[gi*HW+HW-1], a_rd_reg[gi*HW +: HW]};
         assign b_x = {b_rd_reg[gi*HW+HW-1], b_rd_reg[gi*HW +: HW]};
         assign sum = op_reg ? (a_x - b_x) : (a_x + b_x);
`ifdef CMPLX_ADDSUB_SAT_EN
         assign res_value[gi*RW +: RW] = clamp_part(sum);
`else
         assign res_value[gi*RW +: RW] = sum;
`endif
      end
   endgenerate

   // Result buffer write, one element per COMPUTE cycle
   always_ff @(posedge clk) begin
      if (res_wr_en) begin
         res_mem[index_reg] <= res_value;
      end
   end

   // Output register: holds while stalled, reloads on each accepted beat
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_reg <= '0;
      end else if (out_clr) begin
         out_data_reg <= '0;
      end else if (out_ld_en) begin
         if (res_wr_en && (out_ld_addr == index_reg))
            out_data_reg <= res_value;
         else
            out_data_reg <= res_mem[out_ld_addr];
      end
   end

   assign out_data = out_data_reg;
   assign done     = done_reg;

endmodule

// File: tb/tb_complex_matrix_addsub_stream.sv
// Directed testbench for complex_matrix_addsub_stream (2x2, DW=16).
// Expected values are hand-computed; the saturating variants apply when
// CMPLX_ADDSUB_SAT_EN is defined.
module tb_complex_matrix_addsub_stream;

   typedef logic [15:0] vec_t [4];
   typedef logic [17:0] res_t [4];

   logic        clk = 1'b0;
   logic        rst, start, op, in_valid, out_ready;
   logic [15:0] a_in, b_in;
   logic        in_ready, out_valid, busy, done;
   logic [17:0] out_data;

   int cyc = 0;
   int pass_cnt = 0;
   int total_cnt = 0;

   complex_matrix_addsub_stream #(.ROWS(2), .COLS(2), .DW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic o);
      start = 1'b1;
      op    = o;
      step();
      start = 1'b0;
   endtask

   task automatic load4(input vec_t a, input vec_t b, input bit gaps, output int hs_cyc);
      hs_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat (i + 1) step();
         end
         in_valid = 1'b1;
         a_in     = a[i];
         b_in     = b[i];
         hs_cyc   = cyc;
         step();
      end
      in_valid = 1'b0;
      a_in     = '0;
      b_in     = '0;
   endtask

   task automatic collect(input bit toggle, output res_t res, output int nres,
                          output int first_cyc, output int unstable, output int early_done);
      int k, guard;
      bit prev_stall;
      logic [17:0] prev_data;
      nres = 0; first_cyc = -1; unstable = 0; early_done = 0;
      k = 0; guard = 0; prev_stall = 1'b0; prev_data = '0;
      for (int i = 0; i < 4; i++) res[i] = '0;
      while (nres < 4 && guard < 80) begin
         if (done) early_done++;
         if (out_valid && first_cyc < 0) first_cyc = cyc;
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) unstable++;
         if (out_valid) begin
            out_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            k++;
         end else begin
            out_ready = 1'b0;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (out_valid && out_ready) begin
            res[nres] = out_data;
            nres++;
         end
         step();
         guard++;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a_in = '0; b_in = '0;
      repeat (3) step();
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 18'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
      rst = 1'b0;
      step();
      $display("txn reset: outputs idle");
   endtask

   task automatic test_add();
      vec_t a, b;
      res_t res;
      int nres, first_cyc, unstable, early_done, hs;
      for (int i = 0; i < 4; i++) begin a[i] = 16'h0101; b[i] = 16'h0101; end
      do_start(1'b0);
      total_cnt++; if (busy !== 1'b1) $display("FAIL add_busy_load: got %b want 1", busy); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL add_in_ready_load: got %b want 1", in_ready); else pass_cnt++;
      load4(a, b, 1'b0, hs);
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL add_in_ready_drop: got %b want 0", in_ready); else pass_cnt++;
      collect(1'b0, res, nres, first_cyc, unstable, early_done);
      total_cnt++; if (nres !== 4) $display("FAIL add_count: got %0d want 4", nres); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (res[i] !== 18'h00402) $display("FAIL add_res%0d: got %h want 00402", i, res[i]); else pass_cnt++;
      end
      total_cnt++; if (early_done !== 0) $display("FAIL add_early_done: got %0d want 0", early_done); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL add_done_pulse: got %b want 1", done); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL add_busy_after: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL add_out_valid_drop: got %b want 0", out_valid); else pass_cnt++;
      step();
      total_cnt++; if (done !== 1'b0) $display("FAIL add_done_single: got %b want 0", done); else pass_cnt++;
      $display("txn add op=0: %0d results", nres);
   endtask

   task automatic test_sub_latch();
      vec_t a, b;
      res_t res;
      int nres, first_cyc, unstable, early_done, hs;
      for (int i = 0; i < 4; i++) begin a[i] = 16'h0101; b[i] = 16'h0101; end
      do_start(1'b1);
      // op flips and a stray start arrive while loading; both must be ignored.
      op = 1'b0;
      start = 1'b1;
      load4(a, b, 1'b0, hs);
      start = 1'b0;
      collect(1'b0, res, nres, first_cyc, unstable, early_done);
      total_cnt++; if (nres !== 4) $display("FAIL sub_count: got %0d want 4", nres); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (res[i] !== 18'h00000) $display("FAIL sub_res%0d: got %h want 00000", i, res[i]); else pass_cnt++;
      end
      total_cnt++; if (done !== 1'b1) $display("FAIL sub_done: got %b want 1", done); else pass_cnt++;
      step();
      $display("txn sub op=1: %0d results", nres);
   endtask

   task automatic test_wide_add();
      vec_t a, b;
      res_t res, exp;
      int nres, first_cyc, unstable, early_done, hs;
      a = '{16'h7F80, 16'h8080, 16'h7F7F, 16'h0000};
      b = '{16'h7F01, 16'h8080, 16'h7F7F, 16'h0000};
`ifdef CMPLX_ADDSUB_SAT_EN
      exp = '{18'h0FF81, 18'h30180, 18'h0FE7F, 18'h00000};
`else
      exp = '{18'h1FD81, 18'h20100, 18'h1FCFE, 18'h00000};
`endif
      do_start(1'b0);
      load4(a, b, 1'b0, hs);
      collect(1'b0, res, nres, first_cyc, unstable, early_done);
      total_cnt++; if (nres !== 4) $display("FAIL wide_count: got %0d want 4", nres); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (res[i] !== exp[i]) $display("FAIL wide_res%0d: got %h want %h", i, res[i], exp[i]); else pass_cnt++;
      end
      step();
      $display("txn wide add: %0d results", nres);
   endtask

   task automatic test_neg_sub();
      vec_t a, b;
      res_t res, exp;
      int nres, first_cyc, unstable, early_done, hs;
      a = '{16'h8000, 16'h0080, 16'h0102, 16'h7F80};
      b = '{16'h0100, 16'h007F, 16'h0304, 16'h807F};
`ifdef CMPLX_ADDSUB_SAT_EN
      exp = '{18'h30000, 18'h00180, 18'h3FDFE, 18'h0FF80};
`else
      exp = '{18'h2FE00, 18'h00101, 18'h3FDFE, 18'h1FF01};
`endif
      do_start(1'b1);
      load4(a, b, 1'b0, hs);
      collect(1'b0, res, nres, first_cyc, unstable, early_done);
      total_cnt++; if (nres !== 4) $display("FAIL neg_count: got %0d want 4", nres); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (res[i] !== exp[i]) $display("FAIL neg_res%0d: got %h want %h", i, res[i], exp[i]); else pass_cnt++;
      end
      step();
      $display("txn neg sub: %0d results", nres);
   endtask

   task automatic test_backpressure();
      vec_t a, b;
      res_t res, exp;
      int nres, first_cyc, unstable, early_done, hs;
      a = '{16'h0100, 16'h0201, 16'h0302, 16'h0403};
      b = '{16'h0101, 16'h0101, 16'h0101, 16'h0101};
      exp = '{18'h00401, 18'h00602, 18'h00803, 18'h00A04};
      do_start(1'b0);
      load4(a, b, 1'b1, hs);
      collect(1'b1, res, nres, first_cyc, unstable, early_done);
      total_cnt++; if (nres !== 4) $display("FAIL bp_count: got %0d want 4", nres); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (res[i] !== exp[i]) $display("FAIL bp_res%0d: got %h want %h", i, res[i], exp[i]); else pass_cnt++;
      end
      total_cnt++; if (first_cyc - hs !== 5) $display("FAIL bp_latency: got %0d want 5", first_cyc - hs); else pass_cnt++;
      total_cnt++; if (unstable !== 0) $display("FAIL bp_stall_stable: got %0d changes want 0", unstable); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL bp_done: got %b want 1", done); else pass_cnt++;
      step();
      $display("txn backpressure: %0d results, latency %0d", nres, first_cyc - hs);
   endtask

   task automatic test_mid_reset();
      vec_t a, b;
      res_t res;
      int nres, first_cyc, unstable, early_done, hs;
      for (int i = 0; i < 4; i++) begin a[i] = 16'h0101; b[i] = 16'h0101; end
      do_start(1'b0);
      in_valid = 1'b1; a_in = 16'h1234; b_in = 16'h4321;
      repeat (2) step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      total_cnt++; if (busy !== 1'b0) $display("FAIL mrst_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL mrst_in_ready: got %b want 0", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL mrst_out_valid: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 18'h0) $display("FAIL mrst_out_data: got %h want 0", out_data); else pass_cnt++;
      rst = 1'b0;
      step();
      do_start(1'b0);
      load4(a, b, 1'b0, hs);
      collect(1'b0, res, nres, first_cyc, unstable, early_done);
      total_cnt++; if (nres !== 4) $display("FAIL mrst_count: got %0d want 4", nres); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (res[i] !== 18'h00402) $display("FAIL mrst_res%0d: got %h want 00402", i, res[i]); else pass_cnt++;
      end
      step();
      $display("txn reset recovery: %0d results", nres);
   endtask

   task automatic test_done_start();
      vec_t a, b;
      res_t res;
      int nres, first_cyc, unstable, early_done, hs;
      for (int i = 0; i < 4; i++) begin a[i] = 16'h0101; b[i] = 16'h0101; end
      do_start(1'b0);
      load4(a, b, 1'b0, hs);
      collect(1'b0, res, nres, first_cyc, unstable, early_done);
      total_cnt++; if (done !== 1'b1) $display("FAIL ds_done: got %b want 1", done); else pass_cnt++;
      start = 1'b1; op = 1'b0;
      step();
      total_cnt++; if (busy !== 1'b0) $display("FAIL ds_start_on_done: got busy %b want 0", busy); else pass_cnt++;
      step();
      start = 1'b0;
      total_cnt++; if (busy !== 1'b1) $display("FAIL ds_start_after_done: got busy %b want 1", busy); else pass_cnt++;
      load4(a, b, 1'b0, hs);
      collect(1'b0, res, nres, first_cyc, unstable, early_done);
      total_cnt++; if (nres !== 4) $display("FAIL ds_count: got %0d want 4", nres); else pass_cnt++;
      total_cnt++; if (res[3] !== 18'h00402) $display("FAIL ds_res3: got %h want 00402", res[3]); else pass_cnt++;
      step();
      $display("txn start after done: %0d results", nres);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_latch();
      test_wide_add();
      test_neg_sub();
      test_backpressure();
      test_mid_reset();
      test_done_start();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
